// File: rtl/mem_router_pkg.sv
// Shared types and helpers for the memory region router.
// Holds the response FSM encoding and the region-mapping predicate.
package mem_router_pkg;

    localparam int MAX_REGIONS = 8;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        WAIT
    } state_t;

    function automatic logic region_is_mapped(input int idx, input int num);
        return idx < num;
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational region decode: index, mapped/slow/illegal flags and per-region strobes.
// Zero latency; no backpressure of its own, strobes follow the accept input.
module mem_region_decode
    import mem_router_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int SEL_W       = 2
) (
    input  logic [SEL_W-1:0]       addr_sel,
    input  logic                   write,
    input  logic                   accept,
    input  logic [NUM_REGIONS-1:0] slow_mask,
    input  logic [NUM_REGIONS-1:0] ro_mask,
    output logic [SEL_W-1:0]       idx,
    output logic                   mapped,
    output logic                   slow,
    output logic                   illegal,
    output logic [NUM_REGIONS-1:0] valid_strb,
    output logic [NUM_REGIONS-1:0] write_strb
);

    logic [NUM_REGIONS-1:0] hit;
    logic                   ro;

    always_comb begin
        idx    = addr_sel;
        mapped = region_is_mapped(32'(addr_sel), NUM_REGIONS);
        hit    = '0;
        // hit stays all-zero for unmapped indices, so every strobe is suppressed
        for (int i = 0; i < NUM_REGIONS; i++) begin
            hit[i] = (addr_sel == SEL_W'(i));
        end
        slow       = |(hit & slow_mask);
        ro         = |(hit & ro_mask);
        valid_strb = accept ? hit : '0;
        write_strb = (accept && write) ? (hit & ~ro_mask) : '0;
        illegal    = accept && (!mapped || (write && ro));
    end

endmodule

// File: rtl/mem_region_router.sv
// Routes the pipeline mem port to N address-decoded regions; reads return 1 cycle (fast) or 2 (slow).
// cpu_stall is high for the single WAIT cycle of a slow read; writes and errors never stall.
module mem_region_router
    import mem_router_pkg::*;
#(
    parameter int                     NUM_REGIONS = 4,
    parameter int                     SEL_LSB     = 17,
    parameter int                     SEL_W       = 2,
    parameter logic [MAX_REGIONS-1:0] SLOW_MASK   = '0,
    parameter logic [MAX_REGIONS-1:0] RO_MASK     = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_valid,
    input  logic                      cpu_write,
    input  logic [3:0]                cpu_wmask,
    input  logic [31:0]               cpu_wdata,
    input  logic [31:0]               cpu_addr,
    output logic [31:0]               cpu_rdata,
    output logic                      cpu_stall,
    output logic                      cpu_err,
    output logic [7:0]                err_count,
    output logic [NUM_REGIONS-1:0]    mem_valid,
    output logic [NUM_REGIONS-1:0]    mem_write,
    output logic [3:0]                mem_wmask,
    output logic [31:0]               mem_wdata,
    output logic [31:0]               mem_addr,
    input  logic [32*NUM_REGIONS-1:0] mem_rdata
);

    state_t           state, state_nxt;
    logic             accept;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] q_sel;
    logic             q_read;
    logic             mapped;
    logic             slow;
    logic             illegal;

    assign cpu_stall = (state == WAIT);
    // rst gates accept so nothing reaches the regions while reset is held or on its release edge
    assign accept    = cpu_valid && !cpu_stall && !rst;

    assign mem_addr  = cpu_addr;
    assign mem_wdata = cpu_wdata;
    assign mem_wmask = cpu_wmask;

    mem_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .SEL_W       (SEL_W)
    ) u_decode (
        .addr_sel   (cpu_addr[SEL_LSB +: SEL_W]),
        .write      (cpu_write),
        .accept     (accept),
        .slow_mask  (SLOW_MASK[NUM_REGIONS-1:0]),
        .ro_mask    (RO_MASK[NUM_REGIONS-1:0]),
        .idx        (idx),
        .mapped     (mapped),
        .slow       (slow),
        .illegal    (illegal),
        .valid_strb (mem_valid),
        .write_strb (mem_write)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (state == WAIT) begin
            state_nxt = RESP;
        end else if (accept) begin
            state_nxt = (slow && !cpu_write) ? WAIT : RESP;
        end
    end

    // q_read is only set for mapped reads, so the mux never selects a nonexistent region
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_sel  <= '0;
            q_read <= 1'b0;
        end else if (accept) begin
            q_sel  <= idx;
            q_read <= !cpu_write && mapped;
        end
    end

    always_comb begin
        cpu_rdata = '0;
        if (state == RESP && q_read) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (q_sel == SEL_W'(i)) begin
                    cpu_rdata = mem_rdata[32*i +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_err   <= 1'b0;
            err_count <= '0;
        end else begin
            cpu_err <= illegal;
            if (illegal && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_region_router.sv
// Directed bench: 3 regions, region 1 slow, region 2 read-only, index 3 unmapped.
module tb_mem_region_router;

    localparam int NR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_valid;
    logic          cpu_write;
    logic [3:0]    cpu_wmask;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          cpu_err;
    logic [7:0]    err_count;
    logic [NR-1:0] mem_valid;
    logic [NR-1:0] mem_write;
    logic [3:0]    mem_wmask;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_addr;
    logic [32*NR-1:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    mem_region_router #(
        .NUM_REGIONS (NR),
        .SEL_LSB     (17),
        .SEL_W       (2),
        .SLOW_MASK   (8'b0000_0010),
        .RO_MASK     (8'b0000_0100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_valid (cpu_valid),
        .cpu_write (cpu_write),
        .cpu_wmask (cpu_wmask),
        .cpu_wdata (cpu_wdata),
        .cpu_addr  (cpu_addr),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cpu_err   (cpu_err),
        .err_count (err_count),
        .mem_valid (mem_valid),
        .mem_write (mem_write),
        .mem_wmask (mem_wmask),
        .mem_wdata (mem_wdata),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a);
        cpu_valid = v;
        cpu_write = w;
        cpu_addr  = a;
    endtask

    initial begin
        mem_rdata = {32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF};
        rst       = 1'b1;
        cpu_wmask = 4'h0;
        cpu_wdata = 32'h0;
        drive(1'b1, 1'b1, 32'h0000_0010);

        // reset state, strobes gated even with a request present
        #2;
        chk("rst_stall", cpu_stall, 0);
        chk("rst_err", cpu_err, 0);
        chk("rst_cnt", err_count, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_mvalid", mem_valid, 0);
        chk("rst_mwrite", mem_write, 0);
        step();
        drive(1'b0, 1'b0, 32'h0);
        rst = 1'b0;

        // fast back-to-back reads: region 0 then region 2
        step();
        drive(1'b1, 1'b0, 32'h0000_0010);
        #1;
        chk("f0_mvalid", mem_valid, 3'b001);
        chk("f0_maddr", mem_addr, 32'h0000_0010);
        chk("f0_stall", cpu_stall, 0);
        step();
        drive(1'b1, 1'b0, 32'h0004_0000);
        #1;
        chk("f1_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("f1_mvalid", mem_valid, 3'b100);
        chk("f1_stall", cpu_stall, 0);
        step();
        drive(1'b0, 1'b0, 32'h0);
        #1;
        chk("f2_rdata", cpu_rdata, 32'hCAFEF00D);
        chk("f2_stall", cpu_stall, 0);
        step();
        chk("f3_idle_rdata", cpu_rdata, 0);

        // slow read of region 1 with a held follow-on request
        drive(1'b1, 1'b0, 32'h0002_0004);
        #1;
        chk("s0_mvalid", mem_valid, 3'b010);
        chk("s0_stall", cpu_stall, 0);
        step();
        drive(1'b1, 1'b0, 32'h0000_0010);
        #1;
        chk("s1_stall", cpu_stall, 1);
        chk("s1_mvalid", mem_valid, 0);
        chk("s1_rdata", cpu_rdata, 0);
        step();
        chk("s2_stall", cpu_stall, 0);
        chk("s2_rdata", cpu_rdata, 32'h12345678);
        chk("s2_mvalid", mem_valid, 3'b001);
        step();
        drive(1'b0, 1'b0, 32'h0);
        #1;
        chk("s3_rdata", cpu_rdata, 32'hDEADBEEF);
        step();

        // slow-region write completes in the accept cycle
        cpu_wmask = 4'h3;
        cpu_wdata = 32'h1122_3344;
        drive(1'b1, 1'b1, 32'h0002_0008);
        #1;
        chk("sw_mwrite", mem_write, 3'b010);
        chk("sw_mvalid", mem_valid, 3'b010);
        chk("sw_wmask", mem_wmask, 4'h3);
        chk("sw_wdata", mem_wdata, 32'h1122_3344);
        step();
        drive(1'b0, 1'b0, 32'h0);
        #1;
        chk("sw_stall", cpu_stall, 0);
        chk("sw_rdata", cpu_rdata, 0);
        chk("sw_err", cpu_err, 0);

        // write to read-only region 2
        cpu_wmask = 4'hF;
        cpu_wdata = 32'hA5A5_A5A5;
        drive(1'b1, 1'b1, 32'h0004_0000);
        #1;
        chk("ro_mwrite", mem_write, 0);
        chk("ro_mvalid", mem_valid, 3'b100);
        step();
        drive(1'b0, 1'b0, 32'h0);
        #1;
        chk("ro_err", cpu_err, 1);
        chk("ro_cnt", err_count, 1);
        chk("ro_rdata", cpu_rdata, 0);
        step();
        chk("ro_err_pulse", cpu_err, 0);

        // unmapped read, index 3
        drive(1'b1, 1'b0, 32'h0006_0000);
        #1;
        chk("um_mvalid", mem_valid, 0);
        chk("um_stall", cpu_stall, 0);
        step();
        drive(1'b0, 1'b0, 32'h0);
        #1;
        chk("um_err", cpu_err, 1);
        chk("um_rdata", cpu_rdata, 0);
        chk("um_cnt", err_count, 2);
        step();

        // 260 more unmapped accesses saturate the counter at 255
        drive(1'b1, 1'b0, 32'h0006_0000);
        for (int i = 0; i < 260; i++) step();
        drive(1'b0, 1'b0, 32'h0);
        #1;
        chk("sat_err", cpu_err, 1);
        chk("sat_cnt", err_count, 255);
        step();
        chk("sat_hold", err_count, 255);

        // reset during a slow read's WAIT cycle
        drive(1'b1, 1'b0, 32'h0002_0000);
        step();
        drive(1'b1, 1'b1, 32'h0000_0010);
        #1;
        chk("rw_stall_pre", cpu_stall, 1);
        rst = 1'b1;
        #1;
        chk("rw_stall", cpu_stall, 0);
        chk("rw_err", cpu_err, 0);
        chk("rw_rdata", cpu_rdata, 0);
        chk("rw_mwrite", mem_write, 0);
        chk("rw_cnt", err_count, 0);
        step();
        drive(1'b1, 1'b0, 32'h0000_0010);
        step();
        rst = 1'b0;
        #1;
        chk("rr_mvalid", mem_valid, 3'b001);
        chk("rr_stall", cpu_stall, 0);
        step();
        drive(1'b0, 1'b0, 32'h0);
        #1;
        chk("rr_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rr_err", cpu_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_region_router.md
# mem_region_router

Parametrised memory-bus router between the RV32 pipeline's data/instruction port and up to eight memory regions (SPRAM, BRAM boot ROM, peripherals). It generalises the fixed two-region SPRAM/BRAM select into N address-decoded regions. Each region has a configurable read latency of one or two cycles, with a stall handshake for slow regions. Writes to read-only regions and accesses to unmapped regions are blocked and flagged. The block sits between the pipeline's `mem_*` port and the memory instances in each board top.

## Interface
- `NUM_REGIONS`, default 4: number of mapped regions, 1..2**SEL_W (max 8).
- `SEL_LSB`, default 17: lowest address bit of the region index.
- `SEL_W`, default 2: region index width; index = `cpu_addr[SEL_LSB +: SEL_W]`.
- `SLOW_MASK`, default 0: bit i = 1 gives region i a 2-cycle read latency.
- `RO_MASK`, default 0: bit i = 1 makes region i read-only.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_valid`  in  1  request present.
- `cpu_write`  in  1  write request.
- `cpu_wmask`  in  4  byte write enables.
- `cpu_wdata`  in  32  write data.
- `cpu_addr`  in  32  byte address.
- `cpu_rdata`  out  32  read data.
- `cpu_stall`  out  1  request not accepted; hold inputs.
- `cpu_err`  out  1  one-cycle error pulse.
- `err_count`  out  8  saturating error count.
- `mem_valid`  out  NUM_REGIONS  per-region select.
- `mem_write`  out  NUM_REGIONS  per-region write strobe.
- `mem_wmask`  out  4  shared byte mask.
- `mem_wdata`  out  32  shared write data.
- `mem_addr`  out  32  shared address.
- `mem_rdata`  in  32*NUM_REGIONS  region i occupies bits [32i +: 32].

## Operation
- A request is accepted in a cycle when `cpu_valid && !cpu_stall`.
- Index `idx` is decoded combinationally. `idx >= NUM_REGIONS` is unmapped.
- `mem_addr`, `mem_wdata` and `mem_wmask` pass through unregistered.
- `mem_valid[idx]` equals accept, unless the region is unmapped.
- `mem_write[idx]` equals accept && `cpu_write` && !`RO_MASK[idx]`.
- An illegal access is either unmapped (read or write) or a write to an RO region:
  - it drives no `mem_write`;
  - `cpu_err` = 1 in the cycle after acceptance;
  - `err_count` increments and saturates at 255.
- FSM states:
  - **IDLE**: no response pending.
  - **RESP**: read data returned this cycle from registered index `q_sel`.
  - **WAIT**: first cycle of a slow read.
- FSM transitions:
  - From IDLE or RESP: accepted slow mapped read → WAIT; any other accept → RESP; no accept → IDLE.
  - From WAIT: → RESP unconditionally.
- `cpu_stall` = (state == WAIT). While stalled, every `mem_valid`/`mem_write` bit is 0, even when `cpu_valid` = 1.
- `cpu_rdata` = `mem_rdata[q_sel]` in RESP when `q_read` && mapped; 0 otherwise (writes, unmapped reads, IDLE, WAIT).
- Slow writes take no WAIT cycle; they complete in the accept cycle.

## Timing
- Reset values: state IDLE, `q_sel` 0, `q_read` 0, `cpu_stall` 0, `cpu_err` 0, `err_count` 0. `cpu_rdata` is 0 and all `mem_*` strobes are 0 while `rst` is high.
- Fast read: accepted at T, data at T+1. A back-to-back request is accepted at T+1, giving full throughput.
- Slow read: accepted at T; T+1 `cpu_stall`=1; T+2 data valid, `cpu_stall`=0, next request accepted at T+2.
- `cpu_err` is registered and asserted at T+1 for one cycle per illegal access.
- Reset asserted in WAIT: the access is abandoned and `cpu_stall` drops asynchronously. A write accepted in the same edge as reset release has no effect.
- `err_count` stays at 255 on further errors; no wrap-around.

## Structure
- Package `mem_router_pkg`:
  - FSM state enum `{IDLE, RESP, WAIT}`;
  - `MAX_REGIONS` = 8;
  - function `region_is_mapped(idx, num)`.
- Sub-module `mem_region_decode` (combinational): inputs addr, write, accept, masks; outputs idx, mapped, slow, illegal, per-region strobes.
- The top instantiates the decode, the FSM, the response mux and the error counter.

## Test plan
- NUM_REGIONS=2, SLOW_MASK=0: read 0x0000_0010 (region 0 returns 0xDEADBEEF), then read 0x0002_0000 (region 1 returns 0x12345678) back to back → `cpu_rdata` = 0xDEADBEEF at T+1 and 0x12345678 at T+2; `cpu_stall` never asserts.
- SLOW_MASK=4'b0010: read 0x0002_0004 at T → `cpu_stall` high at T+1 only, data at T+2. A held next request produces no `mem_valid` at T+1 and is accepted at T+2.
- RO_MASK=4'b0010: write 0xA5A5A5A5, wmask 4'hF to 0x0002_0000 → `mem_write` stays 0, `cpu_err`=1 at T+1, `err_count`=1.
- NUM_REGIONS=3, SEL_W=2: read 0x0006_0000 (idx 3) → `mem_valid`=0, `cpu_rdata`=0 and `cpu_err`=1 at T+1. Repeating 260 times leaves `err_count`=255.
- Assert `rst` during a slow read's WAIT cycle → `cpu_stall`, `cpu_err` and `cpu_rdata` are 0 immediately. The first request after release behaves as from IDLE.
